// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin arbiter/mux.
// Contents: requester count and select width, the two-state FSM
// encoding, and one-hot <-> binary index helpers.
package mux_arb_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Returns the index of the lowest set bit; zero when no bit is set.
  function automatic logic [SEL_W-1:0] onehot2idx(input logic [NREQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (oh[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search.
// Ports:
//   req [3:0] - request vector, bit i = requester i
//   ptr [1:0] - index of the last requester served
//   any       - at least one request present
//   idx [1:0] - winner: first requester set, scanning ptr+1 upward mod 4
// The requester at ptr itself is checked last, so a sole requester
// always wins.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = ptr;
    for (int k = 1; k <= NREQ; k++) begin
      // Index arithmetic wraps naturally in SEL_W bits (3 -> 0).
      cand = ptr + SEL_W'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: 4-input round-robin arbiter with a registered data mux.
//
// Ports:
//   clk, rst         - clock (rising edge), asynchronous active-high reset
//   req[3:0]         - per-requester request
//   lock[3:0]        - per-requester burst lock hint
//   d0..d3[WIDTH-1:0]- requester data
//   ready            - downstream accepts out this cycle
//   grant[3:0]       - registered one-hot grant (zero when idle)
//   sel[1:0]         - registered binary index of grant
//   out[WIDTH-1:0]   - registered selected data
//   valid            - out holds an unaccepted beat
//   dbg_state_o      - current FSM state
//
// Handshake: a beat is presented while valid=1 and is transferred on a
// rising edge where valid=1 and ready=1. While valid=1 and ready=0, grant,
// sel, out and valid hold; req and data changes are ignored. The granted
// requester sees its acceptance as grant[i] & valid & ready.
//
// Optional feature (macro MUX_RR_ARBITER_LOCK_EN): a requester holding
// lock and req at acceptance keeps the grant and streams up to LOCK_MAX
// consecutive beats with no idle cycle between them. Without the macro
// the lock port is ignored and every acceptance returns to IDLE.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  lock,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             ready,
  output logic [NREQ-1:0]  grant,
  output logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output state_t           dbg_state_o
);

  state_t           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic [SEL_W-1:0] ptr_q,   ptr_d;

  logic             win_any;
  logic [SEL_W-1:0] win_idx;
  logic [WIDTH-1:0] win_data;
  logic [WIDTH-1:0] cur_data;

  function automatic logic [WIDTH-1:0] pick_data(
    input logic [SEL_W-1:0] i,
    input logic [WIDTH-1:0] a0,
    input logic [WIDTH-1:0] a1,
    input logic [WIDTH-1:0] a2,
    input logic [WIDTH-1:0] a3
  );
    logic [WIDTH-1:0] r;
    case (i)
      2'd0:    r = a0;
      2'd1:    r = a1;
      2'd2:    r = a2;
      default: r = a3;
    endcase
    return r;
  endfunction

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (win_any),
    .idx (win_idx)
  );

  assign win_data = pick_data(win_idx, d0, d1, d2, d3);
  assign cur_data = pick_data(sel_q, d0, d1, d2, d3);

`ifdef MUX_RR_ARBITER_LOCK_EN
  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             extend;

  // Counter holds beats already delivered in this burst minus one, so
  // the burst extends only while another beat still fits in LOCK_MAX.
  assign extend = lock[sel_q] && req[sel_q] &&
                  (int'(lock_cnt_q) < LOCK_MAX - 1);
`else
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    out_d   = out_q;
    ptr_d   = ptr_q;
`ifdef MUX_RR_ARBITER_LOCK_EN
    lock_cnt_d = lock_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = BUSY;
          grant_d = idx2onehot(win_idx);
          sel_d   = win_idx;
          out_d   = win_data;
        end
      end
      BUSY: begin
        if (ready) begin
`ifdef MUX_RR_ARBITER_LOCK_EN
          if (extend) begin
            // Zero-bubble burst: reload data, keep grant, pointer untouched.
            out_d      = cur_data;
            lock_cnt_d = lock_cnt_q + 1'b1;
          end else begin
            state_d    = IDLE;
            grant_d    = '0;
            ptr_d      = sel_q;
            lock_cnt_d = '0;
          end
`else
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = sel_q;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      out_q   <= '0;
      // Last-served pointer starts at 3 so requester 0 wins first.
      ptr_q   <= SEL_W'(NREQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef MUX_RR_ARBITER_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lock_cnt_q <= '0;
    else     lock_cnt_q <= lock_cnt_d;
  end
`endif

  assign grant       = grant_q;
  assign sel         = sel_q;
  assign out         = out_q;
  assign valid       = (state_q == BUSY);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;
  import mux_arb_pkg::*;

  localparam int WIDTH = 8;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req;
  logic [3:0]       lock;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic             ready;
  logic [3:0]       grant;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out;
  logic             valid;
  state_t           dbg_state;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.WIDTH(WIDTH), .LOCK_MAX(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .lock        (lock),
    .d0          (d0),
    .d1          (d1),
    .d2          (d2),
    .d3          (d3),
    .ready       (ready),
    .grant       (grant),
    .sel         (sel),
    .out         (out),
    .valid       (valid),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0]  exp_q[$];
  logic [7:0]  exp_d_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Advance one cycle; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_out",   32'(out),   32'h0);
    check("rst_sel",   32'(sel),   32'h0);
    tick();
    rst = 1'b0;
  endtask

  // Pop one expected grant/data pair and compare with the current outputs.
  task automatic check_beat(input string tag);
    logic [3:0] eg;
    logic [7:0] ed;
    eg = exp_q.pop_front();
    ed = exp_d_q.pop_front();
    check({tag, "_grant"}, 32'(grant), 32'(eg));
    check({tag, "_valid"}, 32'(valid), (eg != 4'b0) ? 32'h1 : 32'h0);
    if (eg != 4'b0) begin
      check({tag, "_out"}, 32'(out), 32'(ed));
      check({tag, "_sel"}, 32'(sel), 32'(onehot2idx(eg)));
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; lock = '0; ready = 1'b0;
    d0 = 8'hA0; d1 = 8'hB1; d2 = 8'hC2; d3 = 8'hD3;
    #3;
    do_reset();

    // Reset state holds with no requests.
    tick();
    check("idle_valid", 32'(valid), 32'h0);
    check("idle_state", 32'(dbg_state), 32'(IDLE));

    // ---- rotation: all requesting, ready held ----
    req = 4'b1111; ready = 1'b1;
    exp_q   = '{4'b0001, 4'b0, 4'b0010, 4'b0, 4'b0100, 4'b0, 4'b1000, 4'b0, 4'b0001};
    exp_d_q = '{8'hA0, 8'h0, 8'hB1, 8'h0, 8'hC2, 8'h0, 8'hD3, 8'h0, 8'hA0};
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 8) req = 4'b0000;
      check_beat("rot");
    end
    tick();  // beat accepted, ptr = 0
    check("rot_end_valid", 32'(valid), 32'h0);

    // ---- stall: data held while ready low ----
    req = 4'b0100; d2 = 8'h5A; ready = 1'b0;
    tick();
    check("stall_grant", 32'(grant), 32'h4);
    check("stall_out0",  32'(out),   32'h5A);
    req = 4'b0000; d2 = 8'h77;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_out",   32'(out),   32'h5A);
      check("stall_valid", 32'(valid), 32'h1);
    end
    ready = 1'b1;
    tick();  // accepted, ptr = 2
    check("stall_acc_valid", 32'(valid), 32'h0);
    check("stall_acc_grant", 32'(grant), 32'h0);

    // ---- fairness skip: move ptr to 1, then req=1001 ----
    req = 4'b0010;
    tick();
    check("skip_setup", 32'(grant), 32'h2);
    req = 4'b0000;
    tick();  // ptr = 1
    req = 4'b1001;
    tick();
    check("skip_first", 32'(grant), 32'h8);
    check("skip_out",   32'(out),   32'hD3);
    tick();  // ptr = 3
    tick();
    check("skip_second", 32'(grant), 32'h1);
    req = 4'b0000;
    tick();

    // ---- reset mid-beat ----
    req = 4'b0100; ready = 1'b0;
    tick();
    check("mid_busy_valid", 32'(valid), 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(valid), 32'h0);
    check("mid_rst_grant", 32'(grant), 32'h0);
    check("mid_rst_out",   32'(out),   32'h0);
    #1;
    rst = 1'b0;
    req = 4'b1111;
    tick();
    check("post_rst_grant", 32'(grant), 32'h1);
    check("post_rst_out",   32'(out),   32'hA0);
    req = 4'b0000;

    // ---- lock burst ----
    do_reset();
    req = 4'b0011; lock = 4'b0001; ready = 1'b1;
`ifdef MUX_RR_ARBITER_LOCK_EN
    exp_q   = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0, 4'b0010};
    exp_d_q = '{8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'h0, 8'hB1};
`else
    exp_q   = '{4'b0001, 4'b0, 4'b0010, 4'b0, 4'b0001, 4'b0};
    exp_d_q = '{8'hA0, 8'h0, 8'hB1, 8'h0, 8'hA0, 8'h0};
`endif
    for (int i = 0; i < 6; i++) begin
      tick();
      check_beat("lock");
    end
    req = 4'b0000; lock = 4'b0000;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
